// File: rtl/qspi_pkg.sv
//------------------------------------------------------------------------------
// Module  : qspi_pkg
// Brief   : Shared lane-mode and receive-state types for the QSPI receive path.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package qspi_pkg;

   typedef enum logic [1:0] {
      QSPI_SINGLE = 2'b00,
      QSPI_DUAL   = 2'b01,
      QSPI_QUAD   = 2'b10
   } qspi_lane_mode_e;

   typedef enum logic [0:0] {
      RX_IDLE = 1'b0,
      RX_RECV = 1'b1
   } qspi_rx_state_e;

   localparam logic [3:0] c_SPB_SINGLE = 4'd8;
   localparam logic [3:0] c_SPB_DUAL   = 4'd4;
   localparam logic [3:0] c_SPB_QUAD   = 4'd2;

   // Encoding 2'b11 is treated as single lane.
   function automatic logic [3:0] qspi_spb(input logic [1:0] mode);
      logic [3:0] spb;
      case (mode)
         QSPI_DUAL: spb = c_SPB_DUAL;
         QSPI_QUAD: spb = c_SPB_QUAD;
         default:   spb = c_SPB_SINGLE;
      endcase
      return spb;
   endfunction

endpackage

`default_nettype wire

// File: rtl/qspi_rx_shift_reg.sv
//------------------------------------------------------------------------------
// Module  : qspi_rx_shift_reg
// Brief   : QSPI receive deserializer; bytes (or packed words when
//           QSPI_RX_WORD_PACK_EN is defined) handed out over valid/ready.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module qspi_rx_shift_reg
   import qspi_pkg::*;
#(
   parameter int LEN_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [1:0]       mode,
   input  logic [LEN_W-1:0] xfer_len,
   input  logic             sample_en,
   input  logic [3:0]       io_in,
   output logic [31:0]      rx_data,
   output logic [2:0]       rx_nbytes,
   output logic             rx_last,
   output logic             rx_valid,
   input  logic             rx_ready,
   output logic             busy,
   output logic             done,
   output logic             overrun,
   input  logic             clr_overrun
);

   qspi_rx_state_e   r_state;
   qspi_rx_state_e   w_state_next;
   logic [1:0]       r_mode;
   logic [LEN_W-1:0] r_len;
   logic [LEN_W-1:0] r_byte_cnt;
   logic [7:0]       r_sr;
   logic [7:0]       w_sr_next;
   logic [2:0]       r_bit_cnt;
   logic             r_done;

   logic             w_sample;
   logic             w_byte_done;
   logic             w_last_byte;
   logic             w_unit;
   logic [31:0]      w_unit_data;
   logic [2:0]       w_unit_nbytes;

   logic [31:0]      r_rx_data;
   logic [2:0]       r_rx_nbytes;
   logic             r_rx_last;
   logic             r_rx_valid;
   logic             r_overrun;

   // start takes priority over a coincident sample.
   assign w_sample    = sample_en && (r_state == RX_RECV) && !start;
   assign w_byte_done = w_sample && (({1'b0, r_bit_cnt} + 4'd1) == qspi_spb(r_mode));
   assign w_last_byte = (r_byte_cnt + LEN_W'(1)) == r_len;

   always_comb begin
      w_sr_next = r_sr;
      case (r_mode)
         QSPI_DUAL: w_sr_next = {r_sr[5:0], io_in[1:0]};
         QSPI_QUAD: w_sr_next = {r_sr[3:0], io_in[3:0]};
         default:   w_sr_next = {r_sr[6:0], io_in[1]};
      endcase
   end

`ifdef QSPI_RX_WORD_PACK_EN
   logic [31:0] r_word;
   logic [1:0]  r_wcnt;
   logic [31:0] w_word_next;

   assign w_word_next   = r_word | ({24'h0, w_sr_next} << {r_wcnt, 3'b000});
   assign w_unit        = w_byte_done && ((r_wcnt == 2'd3) || w_last_byte);
   assign w_unit_data   = w_word_next;
   assign w_unit_nbytes = {1'b0, r_wcnt} + 3'd1;
`else
   assign w_unit        = w_byte_done;
   assign w_unit_data   = {24'h0, w_sr_next};
   assign w_unit_nbytes = 3'd1;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= RX_IDLE;
      else        r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      if (start)
         w_state_next = (xfer_len != '0) ? RX_RECV : RX_IDLE;
      else if (w_byte_done && w_last_byte)
         w_state_next = RX_IDLE;
   end

   // Shift register, bit/byte counters, transfer latches and done pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mode     <= 2'b00;
         r_len      <= '0;
         r_sr       <= 8'h00;
         r_bit_cnt  <= 3'd0;
         r_byte_cnt <= '0;
         r_done     <= 1'b0;
`ifdef QSPI_RX_WORD_PACK_EN
         r_word     <= 32'h0;
         r_wcnt     <= 2'd0;
`endif
      end else begin
         r_done <= 1'b0;
         if (start) begin
            r_mode     <= mode;
            r_len      <= xfer_len;
            r_sr       <= 8'h00;
            r_bit_cnt  <= 3'd0;
            r_byte_cnt <= '0;
            r_done     <= (xfer_len == '0);
`ifdef QSPI_RX_WORD_PACK_EN
            r_word     <= 32'h0;
            r_wcnt     <= 2'd0;
`endif
         end else if (w_sample) begin
            r_sr <= w_sr_next;
            if (w_byte_done) begin
               r_bit_cnt  <= 3'd0;
               r_byte_cnt <= r_byte_cnt + LEN_W'(1);
               r_done     <= w_last_byte;
`ifdef QSPI_RX_WORD_PACK_EN
               if (w_unit) begin
                  r_word <= 32'h0;
                  r_wcnt <= 2'd0;
               end else begin
                  r_word <= w_word_next;
                  r_wcnt <= r_wcnt + 2'd1;
               end
`endif
            end else begin
               r_bit_cnt <= r_bit_cnt + 3'd1;
            end
         end
      end
   end

   // Holding register; a unit arriving while it is full and not drained is lost.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rx_data   <= 32'h0;
         r_rx_nbytes <= 3'd0;
         r_rx_last   <= 1'b0;
         r_rx_valid  <= 1'b0;
         r_overrun   <= 1'b0;
      end else begin
         if (w_unit && (!r_rx_valid || rx_ready)) begin
            r_rx_data   <= w_unit_data;
            r_rx_nbytes <= w_unit_nbytes;
            r_rx_last   <= w_last_byte;
            r_rx_valid  <= 1'b1;
         end else if (r_rx_valid && rx_ready) begin
            r_rx_nbytes <= 3'd0;
            r_rx_last   <= 1'b0;
            r_rx_valid  <= 1'b0;
         end

         if (w_unit && r_rx_valid && !rx_ready)
            r_overrun <= 1'b1;
         else if (clr_overrun)
            r_overrun <= 1'b0;
      end
   end

   assign rx_data   = r_rx_data;
   assign rx_nbytes = r_rx_nbytes;
   assign rx_last   = r_rx_last;
   assign rx_valid  = r_rx_valid;
   assign busy      = (r_state == RX_RECV);
   assign done      = r_done;
   assign overrun   = r_overrun;

endmodule

`default_nettype wire
